// File: rtl/pc_fetch_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_pkg : shared state encoding and default widths for the fetch unit
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pc_fetch_pkg;

  localparam int DEF_D        = 12;
  localparam int DEF_LW       = 8;
  localparam int DEF_START_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RUN        = 2'd1,
    ST_BR_RESOLVE = 2'd2,
    ST_HALTED     = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl : program counter and fetch sequencing; issues LUT index on a
//                 taken branch and applies the returned signed offset next cycle
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int D        = DEF_D,
  parameter int LW       = DEF_LW,
  parameter int START_PC = DEF_START_PC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          halt,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic [LW-1:0] branch_idx,
  output logic [LW-1:0] lut_addr,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          done
);

  localparam logic [D-1:0] c_START  = D'(START_PC);
  localparam logic [D-1:0] c_PC_ONE = D'(1);

  state_t        r_state;
  logic [D-1:0]  r_pc;
  logic [LW-1:0] r_lut_addr;

  state_t        w_state_nxt;
  logic [D-1:0]  w_pc_nxt;
  logic [LW-1:0] w_lut_addr_nxt;
  logic          w_br_take;

  assign w_br_take = branch_en && branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_lut_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_lut_addr <= w_lut_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_lut_addr_nxt = r_lut_addr;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = c_START;
        end
      end
      ST_RUN: begin
        // halt outranks a same-cycle branch, which is simply dropped
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (!stall) begin
          if (w_br_take) begin
            w_lut_addr_nxt = branch_idx;
            w_state_nxt    = ST_BR_RESOLVE;
          end else begin
            w_pc_nxt = r_pc + c_PC_ONE;
          end
        end
      end
      ST_BR_RESOLVE: begin
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (!stall) begin
          // offset is two's complement; a plain D-bit add wraps correctly
          w_pc_nxt    = r_pc + lut_target;
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = c_START;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign prog_ctr    = r_pc;
  assign lut_addr    = r_lut_addr;
  assign fetch_valid = (r_state == ST_RUN) && !stall;
  assign done        = (r_state == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl : directed scoreboard bench for pc_fetch_ctrl with a small
//                    branch-target table standing in for the external LUT
// Revision         : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_ctrl;

  localparam int D  = 12;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          halt;
  logic          stall;
  logic          branch_en;
  logic          branch_taken;
  logic [LW-1:0] branch_idx;
  logic [LW-1:0] lut_addr;
  logic [D-1:0]  lut_target;
  logic [D-1:0]  prog_ctr;
  logic          fetch_valid;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [D-1:0]  pc;
    logic [LW-1:0] la;
    logic          fv;
    logic          dn;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  // Branch-target table: idx0=-5, idx1=+20, idx2=-1, idx3=-14, others 0
  always_comb begin
    lut_target = '0;
    case (lut_addr)
      8'd0:    lut_target = 12'hFFB;
      8'd1:    lut_target = 12'd20;
      8'd2:    lut_target = 12'hFFF;
      8'd3:    lut_target = 12'hFF2;
      default: lut_target = '0;
    endcase
  end

  pc_fetch_ctrl #(.D(D), .LW(LW), .START_PC(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt         (halt),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .lut_addr     (lut_addr),
    .lut_target   (lut_target),
    .prog_ctr     (prog_ctr),
    .fetch_valid  (fetch_valid),
    .done         (done)
  );

  task automatic push(input logic [D-1:0] pc, input logic [LW-1:0] la,
                      input logic fv, input logic dn);
    exp_t e;
    e.pc = pc; e.la = la; e.fv = fv; e.dn = dn;
    q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    n_assert++;
    assert (q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue, expected an entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      n_assert++;
      assert (prog_ctr === e.pc) else begin
        n_fail++;
        $error("FAIL %s prog_ctr: observed %h expected %h", tag, prog_ctr, e.pc);
      end
      n_assert++;
      assert (lut_addr === e.la) else begin
        n_fail++;
        $error("FAIL %s lut_addr: observed %h expected %h", tag, lut_addr, e.la);
      end
      n_assert++;
      assert (fetch_valid === e.fv) else begin
        n_fail++;
        $error("FAIL %s fetch_valid: observed %b expected %b", tag, fetch_valid, e.fv);
      end
      n_assert++;
      assert (done === e.dn) else begin
        n_fail++;
        $error("FAIL %s done: observed %b expected %b", tag, done, e.dn);
      end
    end
  endtask

  // one clock with the current inputs, then compare the post-edge outputs
  task automatic tick(input string tag, input logic [D-1:0] pc,
                      input logic [LW-1:0] la, input logic fv, input logic dn);
    push(pc, la, fv, dn);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; stall = 0;
    branch_en = 0; branch_taken = 0; branch_idx = '0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    push(12'h000, 8'h00, 1'b0, 1'b0);
    check("reset_state");
    reset = 0;
    tick("idle_hold", 12'h000, 8'h00, 1'b0, 1'b0);

    // start then sequential fetch
    start = 1;
    tick("start", 12'h000, 8'h00, 1'b1, 1'b0);
    start = 0;
    for (int k = 1; k <= 4; k++) tick("seq", D'(k), 8'h00, 1'b1, 1'b0);

    // taken branch at 4 with offset -1 -> 3, one bubble
    branch_en = 1; branch_taken = 1; branch_idx = 8'd2;
    tick("br_req_m1", 12'h004, 8'd2, 1'b0, 1'b0);
    idle_inputs();
    tick("br_res_m1", 12'h003, 8'd2, 1'b1, 1'b0);

    // offset -5 from 3 wraps to 0xFFE, then free-run through 0xFFF -> 0x000
    branch_en = 1; branch_taken = 1; branch_idx = 8'd0;
    tick("br_req_m5", 12'h003, 8'd0, 1'b0, 1'b0);
    idle_inputs();
    tick("br_res_wrap", 12'hFFE, 8'd0, 1'b1, 1'b0);
    tick("run_fff", 12'hFFF, 8'd0, 1'b1, 1'b0);
    tick("run_wrap0", 12'h000, 8'd0, 1'b1, 1'b0);
    tick("run_1", 12'h001, 8'd0, 1'b1, 1'b0);
    tick("run_2", 12'h002, 8'd0, 1'b1, 1'b0);

    // +20 branch stalled three cycles in resolve
    branch_en = 1; branch_taken = 1; branch_idx = 8'd1;
    tick("br_req_p20", 12'h002, 8'd1, 1'b0, 1'b0);
    idle_inputs();
    stall = 1;
    for (int k = 0; k < 3; k++) tick("br_stall", 12'h002, 8'd1, 1'b0, 1'b0);
    stall = 0;
    tick("br_res_p20", 12'd22, 8'd1, 1'b1, 1'b0);

    // not-taken branch increments; lut_addr unaffected
    branch_en = 1; branch_taken = 0; branch_idx = 8'd3;
    tick("br_not_taken", 12'd23, 8'd1, 1'b1, 1'b0);
    idle_inputs();
    stall = 1;
    tick("run_stall", 12'd23, 8'd1, 1'b0, 1'b0);
    stall = 0;

    // -14 from 23 reaches 9
    branch_en = 1; branch_taken = 1; branch_idx = 8'd3;
    tick("br_req_m14", 12'd23, 8'd3, 1'b0, 1'b0);
    idle_inputs();
    tick("br_res_m14", 12'd9, 8'd3, 1'b1, 1'b0);

    // halt beats a same-cycle taken branch
    halt = 1; branch_en = 1; branch_taken = 1; branch_idx = 8'd5;
    tick("halt_vs_br", 12'd9, 8'd3, 1'b0, 1'b1);
    idle_inputs();
    halt = 1;
    tick("halted_hold", 12'd9, 8'd3, 1'b0, 1'b1);
    halt = 0;

    // restart from HALTED
    start = 1;
    tick("restart", 12'h000, 8'd3, 1'b1, 1'b0);
    start = 0;
    for (int k = 1; k <= 7; k++) tick("seq2", D'(k), 8'd3, 1'b1, 1'b0);

    // asynchronous reset between edges at pc=7
    #3;
    reset = 1;
    #1;
    push(12'h000, 8'h00, 1'b0, 1'b0);
    check("async_reset");
    @(posedge clk);
    #2;
    reset = 0;
    tick("post_reset_idle", 12'h000, 8'h00, 1'b0, 1'b0);

    // start with stall high: in RUN but no fetch
    start = 1; stall = 1;
    tick("start_stalled", 12'h000, 8'h00, 1'b0, 1'b0);
    start = 0; stall = 0;
    tick("run_after_stall", 12'h001, 8'h00, 1'b1, 1'b0);

    // halt during resolve abandons the branch
    branch_en = 1; branch_taken = 1; branch_idx = 8'd1;
    tick("br_req_p20b", 12'h001, 8'd1, 1'b0, 1'b0);
    idle_inputs();
    halt = 1;
    tick("halt_in_resolve", 12'h001, 8'd1, 1'b0, 1'b1);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
